// File: rtl/systol_mem_sched_pkg.sv
// Shared definitions for the systolic-array memory scheduler: FSM states,
// read-owner encoding and default memory geometry.
package systol_mem_sched_pkg;

   localparam int AW_DEF = 14;
   localparam int DW_DEF = 8;
   localparam int RC_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef enum logic {
      OWN_HOST = 1'b0,
      OWN_CORE = 1'b1
   } owner_e;

endpackage

// File: rtl/systol_mem_sched_sat_counter.sv
// Clear/enable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/systol_mem_sched.sv
// Arbitrates one single-port RAM between the host (idle only) and the systolic
// array (run only), sequences a computation and counts its cycles.
module systol_mem_sched
   import systol_mem_sched_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   input  logic          go,
   output logic          busy,
   output logic          done,
   output logic [15:0]   run_cycles,
   output logic          core_start,
   input  logic          core_finish,
   input  logic          core_rreq,
   input  logic [AW-1:0] core_raddr,
   output logic          core_rvalid,
   output logic [DW-1:0] core_rdata,
   output logic          core_stall,
   input  logic          core_we,
   input  logic [AW-1:0] core_waddr,
   input  logic [DW-1:0] core_wdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   state_e        state_q, state_d;
   logic          core_start_q, core_start_d;
   logic          done_q, done_d;
   logic          rd_pend_q, rd_pend_d;
   owner_e        rd_tag_q, rd_tag_d;

   logic          en_raw;
   logic          we_raw;
   logic [AW-1:0] addr_raw;
   logic [DW-1:0] wdata_raw;
   logic          gnt_raw;
   logic          stall_raw;
   owner_e        owner_raw;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (go) state_d = ST_START;
         ST_START: state_d = ST_RUN;
         ST_RUN:   if (core_finish) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Memory port mux: host owns the RAM in IDLE, the array in RUN; writes beat reads.
   always_comb begin
      en_raw    = 1'b0;
      we_raw    = 1'b0;
      addr_raw  = '0;
      wdata_raw = '0;
      gnt_raw   = 1'b0;
      stall_raw = 1'b0;
      owner_raw = OWN_HOST;
      if (state_q == ST_IDLE) begin
         gnt_raw = host_req;
         if (host_req) begin
            en_raw    = 1'b1;
            we_raw    = host_we;
            addr_raw  = host_addr;
            wdata_raw = host_wdata;
         end
      end else if (state_q == ST_RUN) begin
         owner_raw = OWN_CORE;
         if (core_we) begin
            en_raw    = 1'b1;
            we_raw    = 1'b1;
            addr_raw  = core_waddr;
            wdata_raw = core_wdata;
            stall_raw = core_rreq;
         end else if (core_rreq) begin
            en_raw   = 1'b1;
            addr_raw = core_raddr;
         end
      end
   end

   always_comb begin
      core_start_d = (state_d == ST_START);
      done_d       = (state_d == ST_DONE);
      rd_pend_d    = en_raw && !we_raw;
      rd_tag_d     = owner_raw;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
         rd_pend_q    <= 1'b0;
         rd_tag_q     <= OWN_HOST;
      end else begin
         state_q      <= state_d;
         core_start_q <= core_start_d;
         done_q       <= done_d;
         rd_pend_q    <= rd_pend_d;
         rd_tag_q     <= rd_tag_d;
      end
   end

   sat_counter #(
      .W (RC_W)
   ) u_run_cnt (
      .clk (clk),
      .rst (rst),
      .clr (state_q == ST_START),
      .en  (state_q == ST_RUN),
      .cnt (run_cycles)
   );

   // Request-side outputs are forced quiet while reset is held.
   assign mem_en      = en_raw && rst;
   assign mem_we      = we_raw && rst;
   assign mem_addr    = addr_raw;
   assign mem_wdata   = wdata_raw;
   assign host_gnt    = gnt_raw && rst;
   assign core_stall  = stall_raw && rst;

   assign busy        = (state_q != ST_IDLE);
   assign core_start  = core_start_q;
   assign done        = done_q;
   assign host_rvalid = rd_pend_q && (rd_tag_q == OWN_HOST);
   assign core_rvalid = rd_pend_q && (rd_tag_q == OWN_CORE);
   assign host_rdata  = mem_rdata;
   assign core_rdata  = mem_rdata;

endmodule

// File: tb/tb_systol_mem_sched.sv
// Directed bench for systol_mem_sched with a behavioural synchronous RAM.
module tb_systol_mem_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_req, host_we;
   logic [13:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_gnt, host_rvalid;
   logic [7:0]  host_rdata;
   logic        go, busy, done;
   logic [15:0] run_cycles;
   logic        core_start, core_finish;
   logic        core_rreq;
   logic [13:0] core_raddr;
   logic        core_rvalid;
   logic [7:0]  core_rdata;
   logic        core_stall;
   logic        core_we;
   logic [13:0] core_waddr;
   logic [7:0]  core_wdata;
   logic        mem_en, mem_we;
   logic [13:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  ram [0:16383];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   systol_mem_sched dut (
      .clk         (clk),
      .rst         (rst),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .go          (go),
      .busy        (busy),
      .done        (done),
      .run_cycles  (run_cycles),
      .core_start  (core_start),
      .core_finish (core_finish),
      .core_rreq   (core_rreq),
      .core_raddr  (core_raddr),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .core_stall  (core_stall),
      .core_we     (core_we),
      .core_waddr  (core_waddr),
      .core_wdata  (core_wdata),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   typedef struct packed {
      logic        req;
      logic        we;
      logic [13:0] addr;
      logic [7:0]  wdata;
      logic        cwe;
      logic        crreq;
      logic        e_en;
      logic        e_rv;
      logic [7:0]  e_rd;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vt[0] = '{1'b1, 1'b1, 14'h0010, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      vt[1] = '{1'b1, 1'b0, 14'h0010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
      vt[2] = '{1'b1, 1'b1, 14'h0011, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      vt[3] = '{1'b1, 1'b0, 14'h0011, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
      vt[4] = '{1'b0, 1'b0, 14'h0011, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[5] = '{1'b1, 1'b0, 14'h0010, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
      vt[6] = '{1'b1, 1'b0, 14'h0011, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
      vt[7] = '{1'b1, 1'b1, 14'h3FFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      vt[8] = '{1'b1, 1'b0, 14'h3FFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};
      vt[9] = '{1'b1, 1'b1, 14'h0200, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

      rst = 1'b0; go = 1'b0; core_finish = 1'b0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0010; host_wdata = 8'h00;
      core_rreq = 1'b1; core_raddr = 14'h0000; core_we = 1'b1;
      core_waddr = 14'h0000; core_wdata = 8'h00;

      // reset state, combinational outputs quiet while rst is low
      #2;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_gnt", 32'(host_gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall", 32'(core_stall), 32'd0);
      chk("rst_run_cycles", 32'(run_cycles), 32'd0);
      chk("rst_core_start", 32'(core_start), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rvalids", 32'({host_rvalid, core_rvalid}), 32'd0);
      tick(); tick();
      rst = 1'b1; host_req = 1'b0; core_rreq = 1'b0; core_we = 1'b0;

      // IDLE host traffic, core requests ignored
      for (int i = 0; i < 10; i++) begin
         host_req = vt[i].req; host_we = vt[i].we;
         host_addr = vt[i].addr; host_wdata = vt[i].wdata;
         core_we = vt[i].cwe; core_rreq = vt[i].crreq;
         core_waddr = 14'h0123; core_raddr = 14'h0321; core_wdata = 8'h11;
         #1;
         chk($sformatf("v%0d_gnt", i), 32'(host_gnt), 32'(vt[i].req));
         chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vt[i].e_en));
         chk($sformatf("v%0d_stall", i), 32'(core_stall), 32'd0);
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
         if (vt[i].e_en) begin
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].we));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].addr));
            if (vt[i].we) chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vt[i].wdata));
         end
         tick();
         chk($sformatf("v%0d_host_rvalid", i), 32'(host_rvalid), 32'(vt[i].e_rv));
         chk($sformatf("v%0d_core_rvalid", i), 32'(core_rvalid), 32'd0);
         if (vt[i].e_rv) chk($sformatf("v%0d_host_rdata", i), 32'(host_rdata), 32'(vt[i].e_rd));
      end
      host_req = 1'b0; host_we = 1'b0; core_we = 1'b0; core_rreq = 1'b0;

      // go, finish 10 cycles after core_start, host held off during the run
      go = 1'b1;
      tick();
      go = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0010;
      #1;
      chk("c0_core_start", 32'(core_start), 32'd1);
      chk("c0_busy", 32'(busy), 32'd1);
      chk("c0_gnt", 32'(host_gnt), 32'd0);
      chk("c0_mem_en", 32'(mem_en), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         core_finish = (k == 10);
         chk($sformatf("run%0d_core_start", k), 32'(core_start), 32'd0);
         chk($sformatf("run%0d_busy_done_gnt", k), 32'({busy, done, host_gnt}), 32'b100);
      end
      tick();
      core_finish = 1'b0;
      chk("drain_busy_done", 32'({busy, done}), 32'b10);
      chk("drain_run_cycles", 32'(run_cycles), 32'd10);
      tick();
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_gnt", 32'(host_gnt), 32'd0);
      tick();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_gnt_first", 32'(host_gnt), 32'd1);
      chk("idle_mem_en", 32'(mem_en), 32'd1);
      chk("idle_run_cycles", 32'(run_cycles), 32'd10);
      tick();
      host_req = 1'b0;
      chk("held_read_rvalid", 32'(host_rvalid), 32'd1);
      chk("held_read_rdata", 32'(host_rdata), 32'hA5);

      // go and core_finish together in IDLE
      go = 1'b1; core_finish = 1'b1;
      tick();
      go = 1'b0; core_finish = 1'b0;
      chk("gofin_start", 32'(core_start), 32'd1);
      tick();
      core_finish = 1'b1;
      chk("gofin_run_busy", 32'(busy), 32'd1);
      tick();
      core_finish = 1'b0;
      chk("gofin_run_cycles", 32'(run_cycles), 32'd1);
      tick();
      chk("gofin_done", 32'(done), 32'd1);
      tick();
      chk("gofin_idle", 32'(busy), 32'd0);

      // write/read collision, back-to-back core reads, finish with write
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      core_we = 1'b1; core_waddr = 14'h0100; core_wdata = 8'h77;
      core_rreq = 1'b1; core_raddr = 14'h0200;
      #1;
      chk("col_mem_en", 32'(mem_en), 32'd1);
      chk("col_mem_we", 32'(mem_we), 32'd1);
      chk("col_mem_addr", 32'(mem_addr), 32'h0100);
      chk("col_mem_wdata", 32'(mem_wdata), 32'h77);
      chk("col_stall", 32'(core_stall), 32'd1);
      tick();
      core_we = 1'b0;
      #1;
      chk("rd_mem_en_we", 32'({mem_en, mem_we}), 32'b10);
      chk("rd_mem_addr", 32'(mem_addr), 32'h0200);
      chk("rd_stall", 32'(core_stall), 32'd0);
      chk("rd_no_rvalid", 32'(core_rvalid), 32'd0);
      tick();
      core_raddr = 14'h0100;
      #1;
      chk("b2b1_core_rvalid", 32'(core_rvalid), 32'd1);
      chk("b2b1_core_rdata", 32'(core_rdata), 32'h5A);
      chk("b2b1_host_rvalid", 32'(host_rvalid), 32'd0);
      chk("b2b1_mem_addr", 32'(mem_addr), 32'h0100);
      tick();
      core_rreq = 1'b0; core_we = 1'b1; core_waddr = 14'h0300; core_wdata = 8'h99;
      core_finish = 1'b1;
      #1;
      chk("b2b2_core_rvalid", 32'(core_rvalid), 32'd1);
      chk("b2b2_core_rdata", 32'(core_rdata), 32'h77);
      chk("fin_we_mem", 32'({mem_en, mem_we}), 32'b11);
      chk("fin_we_addr", 32'(mem_addr), 32'h0300);
      tick();
      core_finish = 1'b0; core_rreq = 1'b1;
      #1;
      chk("drain_mem_en", 32'(mem_en), 32'd0);
      chk("drain_stall", 32'(core_stall), 32'd0);
      chk("drain_core_rvalid", 32'(core_rvalid), 32'd0);
      tick();
      core_we = 1'b0; core_rreq = 1'b0;
      chk("col_done", 32'(done), 32'd1);
      tick();
      host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0300;
      #1;
      chk("col_idle_gnt", 32'(host_gnt), 32'd1);
      tick();
      host_req = 1'b0;
      chk("fin_write_rvalid", 32'(host_rvalid), 32'd1);
      chk("fin_write_rdata", 32'(host_rdata), 32'h99);
      chk("fin_write_core_rvalid", 32'(core_rvalid), 32'd0);

      // asynchronous reset mid-RUN
      go = 1'b1;
      tick();
      go = 1'b0;
      tick(); tick();
      host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0010;
      #3;
      rst = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_run_cycles", 32'(run_cycles), 32'd0);
      chk("arst_mem_en", 32'(mem_en), 32'd0);
      chk("arst_gnt", 32'(host_gnt), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      rst = 1'b1;
      #1;
      chk("arst_rel_gnt", 32'(host_gnt), 32'd1);
      chk("arst_rel_mem_en", 32'(mem_en), 32'd1);
      tick();
      host_req = 1'b0;
      chk("arst_rel_rvalid", 32'(host_rvalid), 32'd1);
      chk("arst_rel_rdata", 32'(host_rdata), 32'hA5);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("arst_no_done%0d", k), 32'({busy, done}), 32'b00);
      end

      // run_cycles saturation
      go = 1'b1;
      tick();
      go = 1'b0;
      for (int k = 1; k <= 70000; k++) begin
         tick();
         if (k == 65535) chk("sat_fffe", 32'(run_cycles), 32'hFFFE);
         if (k == 65536) chk("sat_ffff", 32'(run_cycles), 32'hFFFF);
      end
      core_finish = 1'b1;
      tick();
      core_finish = 1'b0;
      chk("sat_hold", 32'(run_cycles), 32'hFFFF);
      tick();
      chk("sat_done", 32'(done), 32'd1);
      tick();
      chk("sat_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/systol_mem_sched.md
SYSTOL_MEM_SCHED -- requirements
Module: systol_mem_sched

Interface
REQ-001 SHALL have parameter AW, default 14, memory address width.
REQ-002 SHALL have parameter DW, default 8, memory data width.
REQ-003 SHALL have port clk  in  1  single clock for the whole block; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports host_req in 1, host_we in 1, host_addr in AW, host_wdata in DW  host (UART-side) memory request.
REQ-006 SHALL have ports host_gnt out 1, host_rvalid out 1, host_rdata out DW  host grant and read return.
REQ-007 SHALL have ports go in 1 (start computation), busy out 1, done out 1 (one-cycle pulse), run_cycles out 16 (computation cycle count).
REQ-008 SHALL have ports core_start out 1 (one-cycle pulse to the systolic array), core_finish in 1.
REQ-009 SHALL have ports core_rreq in 1, core_raddr in AW, core_rvalid out 1, core_rdata out DW, core_stall out 1  array read port.
REQ-010 SHALL have ports core_we in 1, core_waddr in AW, core_wdata in DW  array result write port.
REQ-011 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_rdata in DW  single-port synchronous RAM, read data one cycle after mem_en&!mem_we.

Function
REQ-012 SHALL implement FSM IDLE, START, RUN, DRAIN, DONE.
REQ-013 IDLE: go=1 -> START; host owns memory; busy=0.
REQ-014 START: core_start=1 for exactly one cycle; run_cycles cleared to 0; -> RUN.
REQ-015 RUN: core_finish=1 -> DRAIN; run_cycles increments every RUN cycle, saturates at 16'hFFFF.
REQ-016 DRAIN: held exactly one cycle so any outstanding read returns; -> DONE.
REQ-017 DONE: done=1 for one cycle; -> IDLE.
REQ-018 busy SHALL be 1 in START, RUN, DRAIN, DONE; go while busy SHALL be ignored.
REQ-019 IDLE: host_gnt=host_req combinationally; mem_* driven from host_* when host_req=1, else mem_en=0.
REQ-020 START..DONE: host_gnt=0; host requests SHALL be held off, never dropped by the block (host keeps host_req high).
REQ-021 RUN priority: core_we over core_rreq; core_we&core_rreq in same cycle -> write issued, core_stall=1, read not issued.
REQ-022 core_stall SHALL be 0 whenever core_rreq is not blocked; 0 outside RUN.
REQ-023 core_rreq/core_we outside RUN SHALL be ignored (mem_en=0 from core side).
REQ-024 A 1-bit read tag register SHALL record the owner of each issued read; next cycle asserts host_rvalid or core_rvalid (never both) with rdata = mem_rdata.
REQ-025 Back-to-back reads SHALL sustain one read per cycle with latency 1.
REQ-026 core_finish coincident with core_we in RUN: the write SHALL be issued, then -> DRAIN.
REQ-027 go and core_finish in the same IDLE cycle: go wins, core_finish ignored.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE and clear read tag, run_cycles, and all registered outputs (core_start, done, host_rvalid, core_rvalid = 0).
REQ-029 Reset mid-RUN SHALL abort with no done pulse; after release the block accepts host traffic in the first cycle.
REQ-030 Combinational outputs SHALL reach IDLE values while rst=0 (mem_en=0, busy=0, core_stall=0).

Structure
REQ-031 A shared package SHALL hold the FSM state enum and AW/DW defaults.
REQ-032 One sub-module, sat_counter (16-bit clear/enable saturating counter), SHALL implement run_cycles; all else flat.

Verification
REQ-033 IDLE host write addr 14'h0010 data 8'hA5, then read same addr -> host_gnt=1 both cycles, host_rvalid=1 next cycle with 8'hA5.
REQ-034 go pulse, core_finish 10 cycles after core_start -> core_start 1 cycle, done pulse 2 cycles after finish, run_cycles=10, busy 1 throughout.
REQ-035 RUN with core_we & core_rreq same cycle (waddr 14'h0100, raddr 14'h0200) -> mem_we=1 addr 14'h0100, core_stall=1; read issued next cycle, core_rvalid one cycle later.
REQ-036 host_req held high during RUN -> host_gnt=0 until IDLE, then granted in first IDLE cycle.
REQ-037 rst=0 pulse mid-RUN -> state IDLE asynchronously, no done pulse, run_cycles=0, busy=0.
REQ-038 RUN held 70000 cycles -> run_cycles saturates at 16'hFFFF, no wrap.
